mandelbrot_iter_ctrl: RTL

MANDELBROT_ITER_CTRL -- requirements
Module: mandelbrot_iter_ctrl

---
 rtl/mandelbrot_iter_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mandelbrot_iter_ctrl.sv
// Mandelbrot point iterator: drives an external combinational z^2+c ALU, one iteration per clock.
// Result after count+2 cycles on escape, max_iter+1 on limit; result holds in DONE until out_ready.
module mandelbrot_iter_ctrl #(
    parameter int WIDTH  = 8,
    parameter int ITER_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_cr,
    input  logic [WIDTH-1:0]  in_ci,
    input  logic [ITER_W-1:0] in_max_iter,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_escaped,
    output logic              busy,
    input  logic              abort,
    output logic [WIDTH-1:0]  alu_cr,
    output logic [WIDTH-1:0]  alu_ci,
    output logic [WIDTH-1:0]  alu_zr,
    output logic [WIDTH-1:0]  alu_zi,
    input  logic [WIDTH-1:0]  alu_zr_next,
    input  logic [WIDTH-1:0]  alu_zi_next,
    input  logic              alu_size,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_cr;
    logic [WIDTH-1:0]  r_ci;
    logic [WIDTH-1:0]  r_zr;
    logic [WIDTH-1:0]  r_zi;
    logic [ITER_W-1:0] r_max;
    logic [ITER_W-1:0] r_cnt;
    logic [ITER_W-1:0] r_out_iter;
    logic              r_out_esc;

    logic              w_accept;
    logic              w_escape;
    logic              w_limit;
    logic              w_step;
    logic [ITER_W:0]   w_cnt_inc;

    // One extra bit so max_iter = 2^ITER_W-1 is reached without the compare wrapping.
    assign w_cnt_inc = {1'b0, r_cnt} + {{ITER_W{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_escape = 1'b0;
        w_limit  = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = (in_max_iter == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (alu_size || alu_overflow) begin
                    w_escape = 1'b1;
                    w_next   = S_DONE;
                end else if (w_cnt_inc == {1'b0, r_max}) begin
                    w_limit = 1'b1;
                    w_next  = S_DONE;
                end else begin
                    w_step = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cr       <= '0;
            r_ci       <= '0;
            r_zr       <= '0;
            r_zi       <= '0;
            r_max      <= '0;
            r_cnt      <= '0;
            r_out_iter <= '0;
            r_out_esc  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cr       <= in_cr;
                r_ci       <= in_ci;
                r_max      <= in_max_iter;
                r_zr       <= '0;
                r_zi       <= '0;
                r_cnt      <= '0;
                r_out_iter <= '0;
                r_out_esc  <= 1'b0;
            end
            // Escape leaves z untouched so the escaping orbit point stays visible.
            if (w_escape) begin
                r_out_iter <= r_cnt;
                r_out_esc  <= 1'b1;
            end
            if (w_limit) begin
                r_out_iter <= r_max;
                r_out_esc  <= 1'b0;
                r_zr       <= alu_zr_next;
                r_zi       <= alu_zi_next;
            end
            if (w_step) begin
                r_zr  <= alu_zr_next;
                r_zi  <= alu_zi_next;
                r_cnt <= w_cnt_inc[ITER_W-1:0];
            end
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state == S_RUN);
    assign out_valid   = (r_state == S_DONE);
    assign out_iter    = r_out_iter;
    assign out_escaped = r_out_esc;
    assign alu_cr      = r_cr;
    assign alu_ci      = r_ci;
    assign alu_zr      = r_zr;
    assign alu_zi      = r_zi;

endmodule
